// File: rtl/sub_32_serial_pkg.sv
// Shared definitions for the serial subtractor: default widths, FSM encoding
// and the slice-count helper.
package sub_32_serial_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/sub_4_lookahead.sv
// Combinational 4-bit subtract slice: s = x + ~y + c_in with full carry lookahead.
module sub_4_lookahead (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] y_n;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign y_n = ~y;
  assign g   = x & y_n;
  assign p   = x ^ y_n;

  // Every carry is a flat sum of products of g/p and c_in; none ripples.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ c[3:0];
  assign c_out = c[4];

endmodule

// File: rtl/sub_32_serial.sv
// Multi-cycle subtractor D = A - B - borrow_in, one SLICE-bit slice per cycle,
// least significant slice first, with valid/ready handshakes on both sides.
module sub_32_serial
  import sub_32_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               borrow_q, borrow_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [SLICE-1:0]   x_s, y_s, s_s;
  logic               c_out;
  logic [WIDTH-1:0]   d_run;
  logic               last;

  // The single slice unit is time-shared; count steers operands in and the sum out.
  always_comb begin
    x_s   = '0;
    y_s   = '0;
    d_run = d_q;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        x_s                     = a_q[k*SLICE +: SLICE];
        y_s                     = b_q[k*SLICE +: SLICE];
        d_run[k*SLICE +: SLICE] = s_s;
      end
    end
  end

  sub_4_lookahead u_slice (
    .x     (x_s),
    .y     (y_s),
    .c_in  (carry_q),
    .s     (s_s),
    .c_out (c_out)
  );

  assign last = (cnt_q == CNT_W'(NSLICE - 1));

  // NOTE: every variable gets its hold value first, so no branch can infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    borrow_d  = borrow_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~borrow_in;
          cnt_d   = '0;
          d_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_d     = d_run;
        carry_d = c_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          borrow_d = ~c_out;
          zero_d   = (d_run == '0);
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_run[WIDTH-1] != a_q[WIDTH-1]);
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign d          = d_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;
  assign ovf        = ovf_q;

endmodule
